// File: rtl/axi_lite_burst_writer.sv
// -----------------------------------------------------------------------------
// axi_lite_burst_writer
//
// Issues a burst of single-beat AXI4-Lite writes to consecutive addresses
// (base + n*INCR_VAL). Only one write is outstanding at a time: AW and W are
// issued together, then the B response is awaited before the next beat.
// A non-OKAY response aborts the remaining beats and raises a sticky error.
//
// Ports
//   clk, arst        clock and synchronous active-high reset
//   i_start          burst request, sampled only while idle
//   i_base_addr      first beat address, captured with i_start
//   i_beats          number of beats, captured with i_start (0 = no traffic)
//   o_beat_idx       current beat index for the external data source
//   i_wdata          data word for o_beat_idx, valid the same cycle
//   o_aw*/i_awready  AXI4-Lite write address channel
//   o_w*/i_wready    AXI4-Lite write data channel (strobes all ones)
//   i_b*/o_bready    AXI4-Lite write response channel
//   o_busy           high whenever not idle
//   o_done           one-cycle pulse at the end of a burst
//   o_error          sticky error flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module axi_lite_burst_writer #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int BEAT_CNT_W     = 5,
   parameter int INCR_VAL       = 4
) (
   input  logic                        clk,
   input  logic                        arst,
   input  logic                        i_start,
   input  logic [AXI_ADDR_WIDTH-1:0]   i_base_addr,
   input  logic [BEAT_CNT_W-1:0]       i_beats,
   output logic [BEAT_CNT_W-1:0]       o_beat_idx,
   input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
   output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
   output logic                        o_awvalid,
   input  logic                        i_awready,
   output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
   output logic                        o_wvalid,
   input  logic                        i_wready,
   input  logic                        i_bvalid,
   input  logic [1:0]                  i_bresp,
   output logic                        o_bready,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_error
);

   typedef enum logic [1:0] {StIdle, StSend, StResp, StDone} state_t;

   state_t                    r_state;
   logic [AXI_ADDR_WIDTH-1:0] r_base;
   logic [BEAT_CNT_W-1:0]     r_beats;
   logic [BEAT_CNT_W-1:0]     r_beat_idx;
   logic                      r_awvalid;
   logic                      r_wvalid;
   logic                      r_error;

   logic                      w_aw_hs;
   logic                      w_w_hs;
   logic                      w_aw_ok;
   logic                      w_w_ok;
   logic [BEAT_CNT_W-1:0]     w_last_idx;

   assign w_aw_hs    = r_awvalid & i_awready;
   assign w_w_hs     = r_wvalid & i_wready;
   // Both valids rise on entry to StSend, so a low valid in StSend means that
   // channel has already handshaken for this beat.
   assign w_aw_ok    = ~r_awvalid | w_aw_hs;
   assign w_w_ok     = ~r_wvalid | w_w_hs;
   assign w_last_idx = r_beats - BEAT_CNT_W'(1);

   always_ff @(posedge clk) begin
      if (arst) begin
         r_state    <= StIdle;
         r_base     <= '0;
         r_beats    <= '0;
         r_beat_idx <= '0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_error <= 1'b0;
                  if (i_beats != '0) begin
                     r_base     <= i_base_addr;
                     r_beats    <= i_beats;
                     r_beat_idx <= '0;
                     r_awvalid  <= 1'b1;
                     r_wvalid   <= 1'b1;
                     r_state    <= StSend;
                  end else begin
                     r_state <= StDone;
                  end
               end
            end
            StSend: begin
               if (w_aw_hs) r_awvalid <= 1'b0;
               if (w_w_hs)  r_wvalid  <= 1'b0;
               if (w_aw_ok && w_w_ok) r_state <= StResp;
            end
            StResp: begin
               if (i_bvalid) begin
                  if (i_bresp != 2'b00) begin
                     r_error <= 1'b1;
                     r_state <= StDone;
                  end else if (r_beat_idx == w_last_idx) begin
                     r_state <= StDone;
                  end else begin
                     r_beat_idx <= r_beat_idx + BEAT_CNT_W'(1);
                     r_awvalid  <= 1'b1;
                     r_wvalid   <= 1'b1;
                     r_state    <= StSend;
                  end
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   // Address wraps modulo 2^AXI_ADDR_WIDTH by truncation of the sum.
   assign o_awaddr   = r_base + (AXI_ADDR_WIDTH'(r_beat_idx) * AXI_ADDR_WIDTH'(INCR_VAL));
   assign o_awvalid  = r_awvalid;
   assign o_wdata    = i_wdata;
   assign o_wstrb    = '1;
   assign o_wvalid   = r_wvalid;
   assign o_bready   = (r_state == StResp);
   assign o_busy     = (r_state != StIdle);
   assign o_done     = (r_state == StDone);
   assign o_error    = r_error;
   assign o_beat_idx = r_beat_idx;

endmodule

// File: tb/tb_axi_lite_burst_writer.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_burst_writer
//
// Self-checking bench: a transaction-level model (pending flags, beat number,
// expected address arithmetic) predicts every output each cycle; directed
// scenarios add literal expectations, then randomized bursts follow.
// -----------------------------------------------------------------------------
module tb_axi_lite_burst_writer;

   logic        clk = 1'b0;
   logic        arst;
   logic        i_start;
   logic [63:0] i_base_addr;
   logic [4:0]  i_beats;
   logic [4:0]  o_beat_idx;
   logic [31:0] i_wdata;
   logic [63:0] o_awaddr;
   logic        o_awvalid;
   logic        i_awready;
   logic [31:0] o_wdata;
   logic [3:0]  o_wstrb;
   logic        o_wvalid;
   logic        i_wready;
   logic        i_bvalid;
   logic [1:0]  i_bresp;
   logic        o_bready;
   logic        o_busy;
   logic        o_done;
   logic        o_error;

   always #5 clk = ~clk;

   axi_lite_burst_writer dut (
      .clk         (clk),
      .arst        (arst),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_beats     (i_beats),
      .o_beat_idx  (o_beat_idx),
      .i_wdata     (i_wdata),
      .o_awaddr    (o_awaddr),
      .o_awvalid   (o_awvalid),
      .i_awready   (i_awready),
      .o_wdata     (o_wdata),
      .o_wstrb     (o_wstrb),
      .o_wvalid    (o_wvalid),
      .i_wready    (i_wready),
      .i_bvalid    (i_bvalid),
      .i_bresp     (i_bresp),
      .o_bready    (o_bready),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_error     (o_error)
   );

   // Data source: word depends only on the beat index presented.
   function automatic logic [31:0] wfun(input logic [4:0] k);
      return 32'h5A00_0011 + ({27'd0, k} * 32'h0001_0203);
   endfunction
   assign i_wdata = wfun(o_beat_idx);

   // ---------------- reference model ----------------
   bit          m_sending, m_aw_pend, m_w_pend, m_wait_b, m_done, m_error;
   logic [63:0] m_base;
   int          m_nbeats, m_k;

   function automatic bit m_busy();
      return m_sending | m_wait_b | m_done;
   endfunction

   task automatic model_step();
      if (arst) begin
         m_sending = 0; m_aw_pend = 0; m_w_pend = 0; m_wait_b = 0;
         m_done = 0; m_error = 0; m_base = '0; m_k = 0; m_nbeats = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_sending) begin
         if (m_aw_pend && i_awready) m_aw_pend = 0;
         if (m_w_pend && i_wready) m_w_pend = 0;
         if (!m_aw_pend && !m_w_pend) begin
            m_sending = 0;
            m_wait_b  = 1;
         end
      end else if (m_wait_b) begin
         if (i_bvalid) begin
            m_wait_b = 0;
            if (i_bresp != 2'b00) begin
               m_error = 1;
               m_done  = 1;
            end else if (m_k + 1 == m_nbeats) begin
               m_done = 1;
            end else begin
               m_k++;
               m_sending = 1; m_aw_pend = 1; m_w_pend = 1;
            end
         end
      end else if (i_start) begin
         m_error = 0;
         if (i_beats == 0) begin
            m_done = 1;
         end else begin
            m_base = i_base_addr; m_nbeats = int'(i_beats); m_k = 0;
            m_sending = 1; m_aw_pend = 1; m_w_pend = 1;
         end
      end
   endtask

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("awvalid", 64'(o_awvalid), 64'(m_aw_pend));
      chk("wvalid", 64'(o_wvalid), 64'(m_w_pend));
      chk("bready", 64'(o_bready), 64'(m_wait_b));
      chk("busy", 64'(o_busy), 64'(m_busy()));
      chk("done", 64'(o_done), 64'(m_done));
      chk("error", 64'(o_error), 64'(m_error));
      chk("beat_idx", 64'(o_beat_idx), 64'(m_k));
      chk("awaddr", o_awaddr, m_base + 64'(m_k) * 64'd4);
      chk("wstrb", 64'(o_wstrb), 64'hF);
      if (o_wvalid) chk("wdata", 64'(o_wdata), 64'(wfun(5'(m_k))));
   endtask

   // Observed-traffic logs for the directed literal checks.
   logic [63:0] aw_log[$];
   int n_bhs, n_done, n_awv_cyc, n_wv_cyc;

   task automatic clear_logs();
      aw_log.delete();
      n_bhs = 0; n_done = 0; n_awv_cyc = 0; n_wv_cyc = 0;
   endtask

   // Called with inputs settled; the next posedge consumes them.
   task automatic tick();
      if (!arst) begin
         if (o_awvalid && i_awready) aw_log.push_back(o_awaddr);
         if (o_bready && i_bvalid) n_bhs++;
         if (o_done) n_done++;
         if (o_awvalid) n_awv_cyc++;
         if (o_wvalid) n_wv_cyc++;
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic start_burst(input logic [63:0] base, input logic [4:0] beats);
      i_start = 1; i_base_addr = base; i_beats = beats;
      tick();
      i_start = 0; i_base_addr = {$urandom, $urandom}; i_beats = 5'($urandom);
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (m_busy() && n < budget) begin
         tick();
         n++;
      end
      if (m_busy()) begin
         n_chk++; n_err++;
         $display("FAIL wait_idle: still busy after %0d cycles", budget);
         m_sending = 0; m_aw_pend = 0; m_w_pend = 0; m_wait_b = 0; m_done = 0;
      end
   endtask

   int n;

   initial begin
      arst = 1; i_start = 0; i_base_addr = '0; i_beats = '0;
      i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
      @(negedge clk);
      tick();
      tick();
      chk("reset_awaddr", o_awaddr, 64'h0);
      chk("reset_busy", 64'(o_busy), 64'h0);
      arst = 0;
      tick();

      // Basic burst
      clear_logs();
      i_awready = 1; i_wready = 1; i_bvalid = 1; i_bresp = 0;
      start_burst(64'h1000, 5'd4);
      wait_idle(50, n);
      chk("basic_cycles", 64'(n), 64'd9);
      chk("basic_aw_cnt", 64'(aw_log.size()), 64'd4);
      if (aw_log.size() == 4) begin
         chk("basic_aw0", aw_log[0], 64'h1000);
         chk("basic_aw1", aw_log[1], 64'h1004);
         chk("basic_aw2", aw_log[2], 64'h1008);
         chk("basic_aw3", aw_log[3], 64'h100C);
      end
      chk("basic_b_cnt", 64'(n_bhs), 64'd4);
      chk("basic_done_cnt", 64'(n_done), 64'd1);
      chk("basic_error", 64'(o_error), 64'd0);

      // Skewed handshake: awready held off 3 SEND cycles
      clear_logs();
      i_awready = 0; i_wready = 1; i_bvalid = 0;
      start_burst(64'h2000, 5'd1);
      repeat (3) tick();
      chk("skew_no_bready", 64'(o_bready), 64'd0);
      chk("skew_awaddr_held", o_awaddr, 64'h2000);
      i_awready = 1; i_bvalid = 1;
      wait_idle(50, n);
      chk("skew_awv_cycles", 64'(n_awv_cyc), 64'd4);
      chk("skew_wv_cycles", 64'(n_wv_cyc), 64'd1);
      chk("skew_aw_cnt", 64'(aw_log.size()), 64'd1);

      // Error abort on beat 2
      clear_logs();
      start_burst(64'h5000, 5'd8);
      n = 0;
      while (m_busy() && n < 100) begin
         i_bresp = (m_k == 2) ? 2'b10 : 2'b00;
         tick();
         n++;
      end
      i_bresp = 0;
      chk("err_aw_cnt", 64'(aw_log.size()), 64'd3);
      chk("err_error", 64'(o_error), 64'd1);
      chk("err_done_cnt", 64'(n_done), 64'd1);
      start_burst(64'h3000, 5'd1);
      chk("err_cleared", 64'(o_error), 64'd0);
      wait_idle(50, n);

      // Zero beats
      clear_logs();
      start_burst(64'h7000, 5'd0);
      chk("zero_done_now", 64'(o_done), 64'd1);
      wait_idle(10, n);
      chk("zero_done_cnt", 64'(n_done), 64'd1);
      chk("zero_no_valids", 64'(n_awv_cyc + n_wv_cyc), 64'd0);

      // Address wrap
      clear_logs();
      start_burst(64'hFFFF_FFFF_FFFF_FFFC, 5'd2);
      wait_idle(50, n);
      chk("wrap_aw_cnt", 64'(aw_log.size()), 64'd2);
      if (aw_log.size() == 2) begin
         chk("wrap_aw0", aw_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
         chk("wrap_aw1", aw_log[1], 64'h0);
      end

      // Reset in RESP of beat 1
      clear_logs();
      start_burst(64'h8000, 5'd4);
      n = 0;
      while (!(m_wait_b && m_k == 1) && n < 50) begin
         i_bvalid = (m_k != 1);
         tick();
         n++;
      end
      chk("rst_reached_resp1", 64'(o_bready && o_beat_idx == 5'd1), 64'd1);
      arst = 1;
      tick();
      arst = 0;
      chk("rst_outputs", {o_awaddr[31:0], 21'd0, o_beat_idx, o_awvalid, o_wvalid, o_bready,
                          o_busy, o_done, o_error}, 64'h0);
      repeat (3) tick();
      chk("rst_no_done", 64'(n_done), 64'd0);
      i_bvalid = 1;

      // Start while busy is ignored
      clear_logs();
      start_burst(64'h4000, 5'd3);
      n = 0;
      while (m_busy() && n < 50) begin
         i_start = 1; i_base_addr = 64'h9990; i_beats = 5'd7;
         tick();
         n++;
      end
      i_start = 0;
      chk("busy_aw_cnt", 64'(aw_log.size()), 64'd3);
      if (aw_log.size() == 3) chk("busy_aw2", aw_log[2], 64'h4008);
      chk("busy_done_cnt", 64'(n_done), 64'd1);

      // Randomized bursts
      for (int b = 0; b < 150; b++) begin
         int pa, pw, pb;
         logic [4:0] nb;
         pa = $urandom_range(30, 100);
         pw = $urandom_range(30, 100);
         pb = $urandom_range(30, 100);
         nb = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
         i_awready = ($urandom_range(1, 100) <= pa);
         i_wready  = ($urandom_range(1, 100) <= pw);
         i_bvalid  = ($urandom_range(1, 100) <= pb);
         start_burst({$urandom, $urandom}, nb);
         n = 0;
         while (m_busy() && n < 1000) begin
            i_awready = ($urandom_range(1, 100) <= pa);
            i_wready  = ($urandom_range(1, 100) <= pw);
            i_bvalid  = ($urandom_range(1, 100) <= pb);
            i_bresp   = ($urandom_range(0, 40) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            i_start   = ($urandom_range(0, 9) == 0);
            i_beats   = 5'($urandom);
            i_base_addr = {$urandom, $urandom};
            arst      = ($urandom_range(0, 299) == 0);
            tick();
            n++;
         end
         arst = 0; i_start = 0; i_bresp = 0;
         if (m_busy()) begin
            n_chk++; n_err++;
            $display("FAIL random_timeout: burst %0d did not finish", b);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
